// File: rtl/asap_pkg.sv
// Shared definitions for the ASAP configuration block: FSM encoding,
// register offsets, CTRL/STATUS bit positions and a byte-merge helper.
package asap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OFS_ER_MIN = 3'd0;
  localparam logic [2:0] OFS_ER_MAX = 3'd1;
  localparam logic [2:0] OFS_OR_MIN = 3'd2;
  localparam logic [2:0] OFS_OR_MAX = 3'd3;
  localparam logic [2:0] OFS_CTRL   = 3'd4;
  localparam logic [2:0] OFS_STATUS = 3'd5;
  localparam logic [2:0] OFS_DROP   = 3'd6;
  localparam logic [2:0] OFS_RSVD   = 3'd7;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_DISARM  = 1;
  localparam int CTRL_RELEASE = 2;
  localparam int CTRL_CLR_ERR = 3;

  localparam int STAT_EXEC      = 2;
  localparam int STAT_CFG_ERR   = 3;
  localparam int STAT_EXEC_LOST = 4;

  function automatic logic [15:0] byte_merge(input logic [15:0] cur,
                                             input logic [15:0] din,
                                             input logic [1:0]  we);
    logic [15:0] res;
    res = cur;
    if (we[0]) res[7:0]  = din[7:0];
    if (we[1]) res[15:8] = din[15:8];
    return res;
  endfunction

endpackage

// File: rtl/asap_cfg_fsm.sv
// Lock/execution FSM for the ASAP config block, with exec edge tracking
// and the sticky cfg_err / exec_lost flags.
module asap_cfg_fsm
  import asap_pkg::*;
(
  input  logic       clk,
  input  logic       puc_n,
  input  logic       exec,
  input  logic       hw_reset,
  input  logic       arm,
  input  logic       disarm,
  input  logic       rel,
  input  logic       clr_err,
  input  logic       cfg_ok,
  output logic [1:0] state,
  output logic       exec_q,
  output logic       cfg_err,
  output logic       exec_lost,
  output logic       locked
);

  state_t state_q, state_d;
  logic   cfg_err_d, exec_lost_d;
  logic   arm_s, rel_s;

  // Simultaneous strobes resolve as disarm > release > arm.
  assign rel_s = rel & ~disarm;
  assign arm_s = arm & ~disarm & ~rel;

  always_ff @(posedge clk or negedge puc_n) begin
    if (!puc_n) begin
      state_q   <= ST_IDLE;
      exec_q    <= 1'b0;
      cfg_err   <= 1'b0;
      exec_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      exec_q    <= exec;
      cfg_err   <= cfg_err_d;
      exec_lost <= exec_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_err_d   = cfg_err;
    exec_lost_d = exec_lost;
    if (hw_reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_s) begin
            if (cfg_ok) state_d   = ST_ARMED;
            else        cfg_err_d = 1'b1;
          end
        end
        ST_ARMED: begin
          // ARMED is only entered with exec low (from RUN) or just after arm,
          // so exec high here is either a rising edge or already-high-at-arm.
          if (disarm)    state_d = ST_IDLE;
          else if (exec) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (rel_s) begin
            state_d = ST_DONE;
          end else if (!exec) begin
            state_d     = ST_ARMED;
            exec_lost_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (rel_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (clr_err) begin
      cfg_err_d   = 1'b0;
      exec_lost_d = 1'b0;
    end
  end

  assign state  = state_q;
  assign locked = (state_q != ST_IDLE);

endmodule

// File: rtl/asap_cfg.sv
// ASAP region-bound register block on the peripheral bus: bound registers,
// CTRL strobes, STATUS/DROP readback; lock sequencing lives in asap_cfg_fsm.
module asap_cfg
  import asap_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'h0190,
  parameter logic [15:0] ER_RST    = 16'hE000,
  parameter logic [15:0] OR_RST    = 16'h0600
) (
  input  logic        clk,
  input  logic        puc_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        exec,
  input  logic        hw_reset,
  output logic [15:0] ER_min,
  output logic [15:0] ER_max,
  output logic [15:0] OR_min,
  output logic [15:0] OR_max,
  output logic        locked
);

  // Bus protocol: an access is one cycle with per_en high; per_we==0 is a read
  // answered combinationally the same cycle, otherwise the write commits at
  // the next rising clk. There is no backpressure.
  logic       sel, wr, rd, bound_wr, ctrl_wr, idle, cfg_ok;
  logic [2:0] ofs;
  logic [1:0] state;
  logic       exec_q, cfg_err, exec_lost;
  logic [7:0] drop;
  logic [15:0] status, rd_data;

  assign sel      = per_en && (per_addr[13:3] == BASE_ADDR[13:3]);
  assign ofs      = per_addr[2:0];
  assign wr       = sel && (per_we != 2'b00);
  assign rd       = sel && (per_we == 2'b00);
  assign bound_wr = wr && (ofs <= OFS_OR_MAX);
  assign ctrl_wr  = wr && (ofs == OFS_CTRL) && per_we[0];
  assign idle     = (state == ST_IDLE);
  // Arm validity is judged on the current (pre-write) bounds.
  assign cfg_ok   = (ER_min <= ER_max) && (OR_min <= OR_max);

  always_ff @(posedge clk or negedge puc_n) begin
    if (!puc_n) begin
      ER_min <= ER_RST;
      ER_max <= ER_RST;
      OR_min <= OR_RST;
      OR_max <= OR_RST;
    end else if (bound_wr && idle) begin
      case (ofs)
        OFS_ER_MIN: ER_min <= byte_merge(ER_min, per_din, per_we);
        OFS_ER_MAX: ER_max <= byte_merge(ER_max, per_din, per_we);
        OFS_OR_MIN: OR_min <= byte_merge(OR_min, per_din, per_we);
        OFS_OR_MAX: OR_max <= byte_merge(OR_max, per_din, per_we);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge puc_n) begin
    if (!puc_n)                                 drop <= 8'h00;
    else if (bound_wr && !idle && drop != 8'hFF) drop <= drop + 8'h01;
  end

  asap_cfg_fsm u_fsm (
    .clk       (clk),
    .puc_n     (puc_n),
    .exec      (exec),
    .hw_reset  (hw_reset),
    .arm       (ctrl_wr && per_din[CTRL_ARM]),
    .disarm    (ctrl_wr && per_din[CTRL_DISARM]),
    .rel       (ctrl_wr && per_din[CTRL_RELEASE]),
    .clr_err   (ctrl_wr && per_din[CTRL_CLR_ERR]),
    .cfg_ok    (cfg_ok),
    .state     (state),
    .exec_q    (exec_q),
    .cfg_err   (cfg_err),
    .exec_lost (exec_lost),
    .locked    (locked)
  );

  always_comb begin
    status                 = 16'h0000;
    status[1:0]            = state;
    status[STAT_EXEC]      = exec_q;
    status[STAT_CFG_ERR]   = cfg_err;
    status[STAT_EXEC_LOST] = exec_lost;
  end

  always_comb begin
    rd_data = 16'h0000;
    case (ofs)
      OFS_ER_MIN: rd_data = ER_min;
      OFS_ER_MAX: rd_data = ER_max;
      OFS_OR_MIN: rd_data = OR_min;
      OFS_OR_MAX: rd_data = OR_max;
      OFS_STATUS: rd_data = status;
      OFS_DROP:   rd_data = {8'h00, drop};
      OFS_CTRL, OFS_RSVD: rd_data = 16'h0000;
      default:    rd_data = 16'h0000;
    endcase
  end

  assign per_dout = (rd && puc_n) ? rd_data : 16'h0000;

endmodule

// File: tb/tb_asap_cfg.sv
// Directed bench for asap_cfg: bus reads are scored against hand-computed
// values through an expected queue; port values are checked directly.
module tb_asap_cfg;

  logic        clk;
  logic        puc_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        exec;
  logic        hw_reset;
  logic [15:0] ER_min, ER_max, OR_min, OR_max;
  logic        locked;

  localparam logic [13:0] BASE = 14'h0190;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  asap_cfg dut (
    .clk      (clk),
    .puc_n    (puc_n),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .exec     (exec),
    .hw_reset (hw_reset),
    .ER_min   (ER_min),
    .ER_max   (ER_max),
    .OR_min   (OR_min),
    .OR_max   (OR_max),
    .locked   (locked)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: every bus read cycle is compared at the falling edge
  always @(negedge clk) begin
    if (per_en && per_we == 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: per_dout=%h, no expected entry", per_dout);
      end else begin
        logic [15:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (per_dout !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", t, per_dout, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks: called at posedge+1, return at the next posedge+1
  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [2:0] ofs, input logic [15:0] d, input logic [1:0] we);
    per_en = 1'b1; per_addr = BASE + {11'd0, ofs}; per_din = d; per_we = we;
    @(posedge clk); #1;
    per_en = 1'b0; per_we = 2'b00; per_din = 16'h0000;
  endtask

  task automatic bus_rd(input logic [2:0] ofs, input logic [15:0] exp, input string name);
    exp_q.push_back(exp);
    tag_q.push_back(name);
    per_en = 1'b1; per_addr = BASE + {11'd0, ofs}; per_we = 2'b00;
    @(posedge clk); #1;
    per_en = 1'b0;
  endtask

  task automatic read_reset_map(input string pfx);
    logic [15:0] rst_vals [7];
    rst_vals = '{16'hE000, 16'hE000, 16'h0600, 16'h0600, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 7; i++)
      bus_rd(3'(i), rst_vals[i], $sformatf("%s_ofs%0d", pfx, i));
  endtask

  initial begin
    puc_n = 1'b0; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    exec = 1'b0; hw_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 puc_n = 1'b1;
    idle_cycle();

    // reset state
    read_reset_map("reset");
    check("reset_locked", {15'd0, locked}, 16'h0000);
    bus_rd(3'd7, 16'h0000, "reserved");

    // valid arm, then locked write is dropped
    bus_wr(3'd0, 16'hE100, 2'b11);
    bus_wr(3'd1, 16'hE1FF, 2'b11);
    bus_wr(3'd4, 16'h0001, 2'b01);
    bus_rd(3'd5, 16'h0001, "armed_status");
    check("armed_locked", {15'd0, locked}, 16'h0001);
    bus_wr(3'd1, 16'hFFFF, 2'b11);
    bus_rd(3'd1, 16'hE1FF, "locked_er_max");
    check("locked_er_max_port", ER_max, 16'hE1FF);
    bus_rd(3'd6, 16'h0001, "drop_one");
    bus_wr(3'd4, 16'h0002, 2'b01);
    bus_rd(3'd5, 16'h0000, "disarm_status");

    // inverted bounds -> cfg_err, then clr_err
    bus_wr(3'd0, 16'hE200, 2'b11);
    bus_wr(3'd1, 16'hE100, 2'b11);
    bus_wr(3'd4, 16'h0001, 2'b01);
    bus_rd(3'd5, 16'h0008, "cfg_err_set");
    check("cfg_err_locked", {15'd0, locked}, 16'h0000);
    bus_wr(3'd4, 16'h0008, 2'b01);
    bus_rd(3'd5, 16'h0000, "cfg_err_clr");

    // exec sequencing through ARMED/RUN/DONE
    bus_wr(3'd1, 16'hE2FF, 2'b11);
    bus_wr(3'd4, 16'h0001, 2'b01);
    exec = 1'b1;
    bus_rd(3'd5, 16'h0001, "armed_exec_seen");
    bus_rd(3'd5, 16'h0006, "run_status");
    exec = 1'b0;
    idle_cycle();
    bus_rd(3'd5, 16'h0011, "exec_lost");
    exec = 1'b1;
    idle_cycle();
    bus_rd(3'd5, 16'h0016, "rerun_status");
    bus_wr(3'd4, 16'h0004, 2'b01);
    bus_rd(3'd5, 16'h0017, "done_status");
    bus_wr(3'd4, 16'h0001, 2'b01);
    bus_rd(3'd5, 16'h0017, "done_ignores_arm");
    bus_wr(3'd4, 16'h0004, 2'b01);
    bus_rd(3'd5, 16'h0014, "released_idle");
    check("released_locked", {15'd0, locked}, 16'h0000);
    exec = 1'b0;
    bus_wr(3'd4, 16'h0008, 2'b01);

    // hw_reset from RUN
    bus_wr(3'd4, 16'h0001, 2'b01);
    exec = 1'b1;
    idle_cycle();
    bus_rd(3'd5, 16'h0006, "pre_hw_reset");
    hw_reset = 1'b1;
    idle_cycle();
    hw_reset = 1'b0;
    bus_rd(3'd5, 16'h0004, "hw_reset_idle");
    check("hw_reset_er_min", ER_min, 16'hE200);
    check("hw_reset_er_max", ER_max, 16'hE2FF);
    bus_rd(3'd6, 16'h0001, "hw_reset_drop");

    // DROP saturation
    exec = 1'b0;
    idle_cycle();
    bus_wr(3'd4, 16'h0001, 2'b01);
    for (int i = 0; i < 300; i++) bus_wr(3'd2, 16'h1234, 2'b11);
    bus_rd(3'd6, 16'h00FF, "drop_saturated");
    bus_rd(3'd2, 16'h0600, "or_min_untouched");
    bus_wr(3'd4, 16'h0002, 2'b01);

    // byte writes and priority of simultaneous strobes
    bus_wr(3'd2, 16'hABCD, 2'b01);
    bus_rd(3'd2, 16'h06CD, "byte_lo_or_min");
    check("byte_lo_port", OR_min, 16'h06CD);
    bus_wr(3'd3, 16'h1234, 2'b10);
    bus_rd(3'd3, 16'h1200, "byte_hi_or_max");
    bus_wr(3'd4, 16'h0003, 2'b01);
    bus_rd(3'd5, 16'h0000, "disarm_beats_arm");

    // asynchronous reset mid-RUN
    bus_wr(3'd4, 16'h0001, 2'b01);
    exec = 1'b1;
    idle_cycle();
    bus_rd(3'd5, 16'h0006, "pre_puc_run");
    puc_n = 1'b0;
    #1;
    check("puc_locked", {15'd0, locked}, 16'h0000);
    check("puc_er_min", ER_min, 16'hE000);
    check("puc_er_max", ER_max, 16'hE000);
    check("puc_or_min", OR_min, 16'h0600);
    check("puc_or_max", OR_max, 16'h0600);
    exec = 1'b0;
    idle_cycle();
    bus_rd(3'd0, 16'h0000, "read_during_reset");
    puc_n = 1'b1;
    idle_cycle();
    read_reset_map("post_puc");

    repeat (2) idle_cycle();
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/asap_cfg.md
ASAP_CFG -- requirements
Module: asap_cfg

Interface
REQ-001 Parameter BASE_ADDR, default 14'h0190, word address of the register block on the peripheral bus (8 words, offsets 0-7).
REQ-002 Parameter ER_RST, default 16'hE000, reset value of ER_min/ER_max; OR_RST, default 16'h0600, reset value of OR_min/OR_max.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 puc_n  input  1  reset, asynchronous, active-low.
REQ-005 per_addr  input  14  peripheral word address.
REQ-006 per_din  input  16  write data.
REQ-007 per_en  input  1  peripheral access strobe.
REQ-008 per_we  input  2  byte write enables; [0] low byte, [1] high byte; 2'b00 is a read.
REQ-009 per_dout  output  16  read data; 16'h0000 when not selected.
REQ-010 exec  input  1  execution-proof flag from hwmod.
REQ-011 hw_reset  input  1  violation reset from hwmod (active-high).
REQ-012 ER_min, ER_max, OR_min, OR_max  output  16 each  region bounds driven to hwmod.
REQ-013 locked  output  1  high in states ARMED, RUN, DONE.

Function
REQ-014 Register map (offset): 0 ER_MIN, 1 ER_MAX, 2 OR_MIN, 3 OR_MAX, 4 CTRL (write-only strobes: bit0 arm, bit1 disarm, bit2 release, bit3 clr_err), 5 STATUS (RO: [1:0] state, bit2 exec, bit3 cfg_err, bit4 exec_lost), 6 DROP (RO: [7:0] drop count), 7 reserved, reads 0.
REQ-015 Selected = per_en && per_addr[13:3]==BASE_ADDR[13:3]; reads combinational, same cycle; writes take effect at next clk edge.
REQ-016 Bound registers honour per_we bytes independently; writes accepted only in IDLE.
REQ-017 Write to any bound register outside IDLE is discarded and increments DROP, saturating at 8'hFF.
REQ-018 FSM states: IDLE=0, ARMED=1, RUN=2, DONE=3.
REQ-019 IDLE: CTRL.arm with ER_min<=ER_max and OR_min<=OR_max (unsigned) -> ARMED; with either inverted -> stay IDLE, set cfg_err.
REQ-020 ARMED: exec rising (exec=1, previous-cycle exec=0) -> RUN; CTRL.disarm -> IDLE; exec already high at arm -> RUN next cycle.
REQ-021 RUN: exec falls -> ARMED and set exec_lost sticky; CTRL.release -> DONE.
REQ-022 DONE: CTRL.release -> IDLE; all other CTRL bits ignored.
REQ-023 hw_reset=1 in any state -> IDLE next edge, highest priority; bounds retain values; DROP unchanged.
REQ-024 Simultaneous CTRL bits: priority disarm > release > arm; clr_err clears cfg_err and exec_lost independently of state, and wins over a same-cycle set.
REQ-025 Simultaneous bound write and arm in IDLE: arm validity checks pre-write values; write is applied.
REQ-026 STATUS.exec reflects registered exec (one-cycle delay).

Reset
REQ-027 puc_n low: state=IDLE, ER_min=ER_max=ER_RST, OR_min=OR_max=OR_RST, DROP=0, cfg_err=0, exec_lost=0, exec delay reg=0, locked=0.
REQ-028 per_dout is combinational, 16'h0000 during reset; reset release mid-access takes no write that cycle.

Structure
REQ-029 Shared package asap_pkg holds state encoding, register offsets, CTRL/STATUS bit positions.
REQ-030 One sub-module asap_cfg_fsm (state, edge detect, sticky flags); register file and bus decode in top.

Verification
REQ-031 Reset, read offsets 0-6 -> E000,E000,0600,0600,0000,0000,0000; locked=0.
REQ-032 Write ER_MIN=E100, ER_MAX=E1FF, arm -> STATUS state=1, locked=1; write ER_MAX=FFFF -> ER_max stays E1FF, DROP=1.
REQ-033 Write ER_MIN=E200, ER_MAX=E100, arm -> state=0, cfg_err=1; clr_err -> cfg_err=0.
REQ-034 Armed, exec 0->1 -> state=2 next edge; exec 1->0 -> state=1, exec_lost=1; release after re-entering RUN -> state=3, release -> state=0.
REQ-035 In RUN pulse hw_reset one cycle -> state=0, bounds unchanged; 300 locked writes -> DROP=FF.
REQ-036 Byte write per_we=01, data ABCD to OR_MIN in IDLE -> OR_min=06CD; puc_n low mid-RUN -> all REQ-027 values immediately.
